// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq_param.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   ALU_res;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output en, in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, ALU_res, div_by_zero, illegal_op
  );

  modport slave (
    input  en, in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, ALU_res, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready handshake and an iterative restoring divider.
// Define ALU_SEQ_MUL_EN to add an iterative shift-add multiplier on opcode 0010.
module alu_seq_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_res;
  logic             r_dbz;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;

  logic             w_accept;
  logic             w_is_div;
  logic             w_is_mul;
  logic             w_div_zero;
  logic             w_iter_start;
  logic             w_last;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_trial;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH:0]   w_iter_res;

  function automatic logic [WIDTH:0] f_alu(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_DIV:  res = {1'b0, {WIDTH{1'b1}}};
      OP_SHL:  res = {a, 1'b0};
      OP_SHR:  res = {2'b00, a[WIDTH-1:1]};
      OP_ROL:  res = {1'b0, a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  res = {1'b0, a[0], a[WIDTH-1:1]};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_NOR:  res = {1'b0, ~(a | b)};
      OP_NAND: res = {1'b0, ~(a & b)};
      OP_XNOR: res = {1'b0, ~(a ^ b)};
      OP_GT:   res = (WIDTH+1)'(a > b);
      OP_EQ:   res = (WIDTH+1)'(a == b);
      default: res = '0;
    endcase
    return res;
  endfunction

  assign bus.in_ready    = bus.en && (r_state == S_IDLE) && !rst;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.ALU_res     = r_res;
  assign bus.div_by_zero = r_dbz;
  assign bus.illegal_op  = r_ill;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_is_div   = (bus.opcode == OP_DIV);
  assign w_is_mul   = (bus.opcode == OP_MUL);
  assign w_div_zero = (bus.B == '0);
  assign w_last     = (r_cnt == CNT_W'(1));

  // Restoring divide step: dividend bits shift out of r_quo MSB-first while
  // quotient bits shift in at the LSB.
  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_trial = w_div_shift[WIDTH-1:0] - r_b;
  assign w_div_rem   = w_div_ge ? w_div_trial : w_div_shift[WIDTH-1:0];
  assign w_div_quo   = {r_quo[WIDTH-2:0], w_div_ge};

`ifdef ALU_SEQ_MUL_EN
  logic           r_mul;
  logic [WIDTH:0] w_mul_sum;

  assign w_iter_start = w_accept && ((w_is_div && !w_div_zero) || w_is_mul);
  // Shift-add: r_rem accumulates the high half, r_quo holds the multiplier and
  // fills with the low product bits as it shifts right.
  assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : '0);

  always_comb begin
    w_rem_nxt  = w_div_rem;
    w_quo_nxt  = w_div_quo;
    w_iter_res = {1'b0, w_div_quo};
    if (r_mul) begin
      w_rem_nxt  = w_mul_sum[WIDTH:1];
      w_quo_nxt  = {w_mul_sum[0], r_quo[WIDTH-1:1]};
      w_iter_res = {|w_mul_sum[WIDTH:1], w_mul_sum[0], r_quo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul <= 1'b0;
    end else if (w_accept) begin
      r_mul <= w_is_mul;
    end
  end
`else
  assign w_iter_start = w_accept && w_is_div && !w_div_zero;
  assign w_rem_nxt    = w_div_rem;
  assign w_quo_nxt    = w_div_quo;
  assign w_iter_res   = {1'b0, w_div_quo};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_iter_start ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
      r_dbz <= 1'b0;
      r_ill <= 1'b0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_dbz <= w_is_div && w_div_zero;
`ifdef ALU_SEQ_MUL_EN
      r_ill <= 1'b0;
`else
      r_ill <= w_is_mul;
`endif
      r_cnt <= w_iter_start ? CNT_W'(WIDTH) : '0;
      r_quo <= bus.A;
      r_rem <= '0;
      r_b   <= bus.B;
      if (!w_iter_start) r_res <= f_alu(bus.opcode, bus.A, bus.B);
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) r_res <= w_iter_res;
    end
  end
endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed test-plan steps plus random ops.
module tb_alu_seq_param;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the operation definitions, using wide arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W:0] r, output logic dbz, output logic ill, output int lat);
    logic [2*W-1:0] p;
    logic [W-1:0]   t;
    r = '0; dbz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      4'h0: r = (W+1)'(a) + (W+1)'(b);
      4'h1: begin t = a - b; r = {(a < b), t}; end
      4'h2: begin
`ifdef ALU_SEQ_MUL_EN
        p = (2*W)'(a) * (2*W)'(b);
        r = {(p[2*W-1:W] != 0), p[W-1:0]};
        lat = W + 1;
`else
        p = '0;
        ill = 1'b1;
`endif
      end
      4'h3: begin
        if (b == 0) begin r = {1'b0, {W{1'b1}}}; dbz = 1'b1; end
        else begin r = (W+1)'(a / b); lat = W + 1; end
      end
      4'h4: r = (W+1)'(a) * 2;
      4'h5: r = (W+1)'(a / 2);
      4'h6: begin t = (a << 1) | (a >> (W-1)); r = (W+1)'(t); end
      4'h7: begin t = (a >> 1) | (a << (W-1)); r = (W+1)'(t); end
      4'h8: r = (W+1)'(a & b);
      4'h9: r = (W+1)'(a | b);
      4'hA: r = (W+1)'(a ^ b);
      4'hB: begin t = ~(a | b); r = (W+1)'(t); end
      4'hC: begin t = ~(a & b); r = (W+1)'(t); end
      4'hD: begin t = ~(a ^ b); r = (W+1)'(t); end
      4'hE: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
  endtask

  // Issue one op, measure latency, check result, hold it for `stall` cycles, drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W:0] er;
    logic       edbz, eill;
    int         elat, lat;
    model(op, a, b, er, edbz, eill, elat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = op; bus.A = a; bus.B = b; bus.out_ready = 1'b0;
    #1 check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.opcode = 4'($urandom); bus.A = $urandom; bus.B = $urandom;
    @(negedge clk);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_res"}, bus.ALU_res, er);
    check({tag, "_dbz"}, bus.div_by_zero, edbz);
    check({tag, "_ill"}, bus.illegal_op, eill);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_res"}, bus.ALU_res, er);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_drain"}, bus.out_valid, 0);
  endtask

  initial begin
    logic seen;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.en = 1'b1; bus.in_valid = 1'b0; bus.opcode = 4'h0;
    bus.A = '0; bus.B = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_res", bus.ALU_res, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_ill", bus.illegal_op, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", bus.in_ready, 1);

    run_op("add_carry", 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    check("add_carry_const", bus.ALU_res, 33'h1_0000_0000);
    run_op("sub_borrow", 4'h1, 32'd5, 32'd7, 5);
    check("sub_borrow_const", bus.ALU_res, 33'h1_FFFF_FFFE);
    run_op("div_100_7", 4'h3, 32'd100, 32'd7, 0);
    check("div_100_7_const", bus.ALU_res, 33'd14);
    run_op("div_by_zero", 4'h3, 32'd9, 32'd0, 1);
    check("div_by_zero_const", bus.ALU_res, 33'h0_FFFF_FFFF);
    run_op("mul_ovf", 4'h2, 32'h0001_0000, 32'h0001_0000, 0);
`ifdef ALU_SEQ_MUL_EN
    check("mul_ovf_const", bus.ALU_res, 33'h1_0000_0000);
`else
    check("mul_ovf_const", bus.ALU_res, 33'h0);
`endif
    run_op("rol_msb", 4'h6, 32'h8000_0001, 32'h0, 0);
    run_op("ror_lsb", 4'h7, 32'h0000_0001, 32'h0, 0);
    run_op("shl_msb", 4'h4, 32'h8000_0000, 32'h0, 0);
    run_op("eq_equal", 4'hF, 32'h1234_5678, 32'h1234_5678, 0);
    run_op("div_max", 4'h3, 32'hFFFF_FFFF, 32'h0000_0001, 0);

    // Reset ten cycles into a divide, off the clock edge.
    run_op("pre_rst_add", 4'h0, 32'h1234_0000, 32'h0000_5678, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = 4'h3; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_res", bus.ALU_res, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_release_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("midrst_no_output", seen, 0);

    // Enable gating: held request must not be taken while en=0.
    @(negedge clk);
    bus.en = 1'b0; bus.in_valid = 1'b1; bus.opcode = 4'h0; bus.A = 32'd1; bus.B = 32'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("en0_in_ready", bus.in_ready, 0);
      check("en0_out_valid", bus.out_valid, 0);
    end
    bus.en = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("en1_out_valid", bus.out_valid, 1);
    check("en1_res", bus.ALU_res, 3);
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (rop == 4'hF && $urandom_range(0, 1) == 1) rb = ra;
      run_op("rand", rop, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Operands are accepted through a valid/ready handshake. Single-cycle ops complete in one clock; divide runs as an iterative restoring divider over WIDTH cycles.
- Each result is held in an output register until the consumer takes it. The block sits between the operand/decode stage and the writeback stage.

Parameters:
- WIDTH, 32: operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter. Derived; must not be overridden.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- en  in  1  block enable; when 0, no new operation is accepted.
- in_valid  in  1  A/B/opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select (encoding below).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- out_valid  out  1  ALU_res/flags valid.
- out_ready  in  1  consumer accepts the result.
- ALU_res  out  WIDTH+1  result; bit WIDTH is carry/borrow/extension.
- div_by_zero  out  1  divide issued with B==0.
- illegal_op  out  1  opcode not implemented in this build.

Behaviour:
- State machine: IDLE, BUSY, DONE.
- in_ready = en && state==IDLE && !rst (combinational).
- An operation is accepted when in_valid && in_ready at a clock edge. A, B and opcode are captured at that edge; later input changes have no effect.
- Acceptance transitions:
  - non-divide op: IDLE -> DONE; result registered on the same edge; out_valid=1 the next cycle (latency 1).
  - divide with B!=0: IDLE -> BUSY; counter loaded with WIDTH.
  - divide with B==0: IDLE -> DONE at latency 1; ALU_res = {1'b0, all ones}; div_by_zero=1.
- BUSY:
  - one restoring-division step per cycle; counter decrements.
  - when the counter reaches 0: -> DONE.
  - out_valid rises WIDTH+1 cycles after acceptance.
  - ALU_res = {1'b0, quotient}; remainder is discarded.
- DONE:
  - out_valid=1; ALU_res and flags stable.
  - when out_ready=1: -> IDLE; out_valid drops on that edge.
  - no new acceptance is possible until IDLE, so back-to-back throughput is one op per 2 cycles.
- en=0 blocks only acceptance. An operation already in BUSY or DONE completes and drains normally.
- Opcodes (results zero-extended to WIDTH+1 unless stated):
  - 0000 add: {carry, A+B}.
  - 0001 sub: {borrow, A-B}; borrow = (A<B).
  - 0010 mul: see Optional Feature.
  - 0011 div: unsigned A/B.
  - 0100 shl: {A, 1'b0}.
  - 0101 shr: A>>1.
  - 0110 rol: {A[W-2:0], A[W-1]}.
  - 0111 ror: {A[0], A[W-1:1]}.
  - 1000 and, 1001 or, 1010 xor, 1011 nor, 1100 nand, 1101 xnor.
  - 1110 gt: 1 if A>B unsigned, else 0.
  - 1111 eq: 1 if A==B, else 0.
- Flags (div_by_zero, illegal_op) are registered with the result and cleared on every new acceptance.
- Reset, asserted at any time including mid-BUSY:
  - state=IDLE, ALU_res=0, out_valid=0, div_by_zero=0, illegal_op=0, counter=0.
  - any in-flight operation is discarded with no output.
- ALU_res is never X or Z; undefined cases produce 0.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - opcode 0010 runs an iterative shift-add multiply, BUSY for WIDTH cycles; latency WIDTH+1.
  - ALU_res = {ovf, product[W-1:0]}, where ovf=1 if product[2W-1:W] != 0.
- Not defined:
  - 0010 completes at latency 1 with ALU_res=0 and illegal_op=1.
  - no multiplier logic is synthesised.

Test Plan:
- WIDTH=32, add 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid 1 cycle after accept; ALU_res=0x1_00000000.
- sub 5-7 -> ALU_res=0x1_FFFFFFFE. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
- div 100/7 -> out_valid exactly 33 cycles after accept; ALU_res=14. Div 9/0 -> latency 1, ALU_res=0x0_FFFFFFFF, div_by_zero=1.
- Assert rst at cycle 10 of a divide -> out_valid=0 and ALU_res=0 immediately (async). After release, in_ready=1 with en=1.
- en=0 with in_valid=1 for 4 cycles -> no acceptance, out_valid stays 0. Set en=1 -> accepted next edge.
- mul 0x10000 x 0x10000 -> with ALU_SEQ_MUL_EN: ALU_res=0x1_00000000 (ovf=1, low half 0), latency 33. Without it: ALU_res=0, illegal_op=1, latency 1.
